// File: rtl/lane_tx_scheduler.sv
// Transmit-slot scheduler for the two-lane distributer: arbitrates ordered-set
// bursts against group-aligned transport runs and registers the receive controls.
module lane_tx_scheduler #(
    parameter int OS_LEN = 4,
    parameter int TL_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link_en,
    input  logic       os_req,
    input  logic [2:0] os_sel,
    output logic       os_ack,
    input  logic       tl_req,
    output logic       tl_grant,
    output logic [3:0] d_sel,
    output logic       enable_t,
    input  logic       rx_en,
    input  logic       rx_tl,
    output logic       enable_r,
    output logic       data_os,
    output logic       busy
);

    localparam int TL_CW = (TL_MAX > 2) ? $clog2(TL_MAX) : 1;
    localparam logic [3:0]       OS_LAST  = 4'(OS_LEN - 1);
    localparam logic [TL_CW-1:0] TL_LAST  = TL_CW'(TL_MAX - 1);
    localparam logic [TL_CW-1:0] TL_ONE   = TL_CW'(1);
    localparam logic [3:0]       SEL_TL   = 4'h8;
    localparam logic [3:0]       SEL_IDLE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OS   = 2'd1,
        ST_TL   = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [3:0]       os_cnt_r, os_cnt_s;
    logic [2:0]       os_sel_r, os_sel_s;
    logic [1:0]       grp_r, grp_s;
    logic [TL_CW-1:0] tl_cnt_r, tl_cnt_s;
    logic             os_last_s;
    logic             new_os_s;
    logic [3:0]       d_sel_s;
    logic             os_ack_s;
    logic             tl_grant_s;
    logic             busy_s;

    // Next-state arbitration; ordered sets win ties, transport only yields at group ends
    always_comb begin
        state_s   = state_r;
        os_last_s = (os_cnt_r == OS_LAST);
        if (!link_en) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (os_req) begin
                        state_s = ST_OS;
                    end else if (tl_req) begin
                        state_s = ST_TL;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_OS: begin
                    if (!os_last_s) begin
                        state_s = ST_OS;
                    end else if (os_req) begin
                        state_s = ST_OS;
                    end else if (tl_req) begin
                        state_s = ST_TL;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_TL: begin
                    if (grp_r != 2'd3) begin
                        state_s = ST_TL;
                    end else if (os_req && ((tl_cnt_r == TL_LAST) || !tl_req)) begin
                        state_s = ST_OS;
                    end else if (!tl_req) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_TL;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Counter and output decode for the cycle being entered
    always_comb begin
        new_os_s = (state_s == ST_OS) && ((state_r != ST_OS) || os_last_s);
        os_cnt_s = 4'd0;
        os_sel_s = os_sel_r;
        grp_s    = 2'd0;
        tl_cnt_s = '0;
        if (state_s == ST_OS) begin
            if (new_os_s) begin
                os_cnt_s = 4'd0;
                os_sel_s = os_sel;
            end else begin
                os_cnt_s = os_cnt_r + 4'd1;
            end
        end else begin
            os_cnt_s = 4'd0;
        end
        // Run length saturates; it only matters once it reaches TL_MAX
        if ((state_s == ST_TL) && (state_r == ST_TL)) begin
            grp_s    = grp_r + 2'd1;
            tl_cnt_s = (tl_cnt_r == TL_LAST) ? tl_cnt_r : (tl_cnt_r + TL_ONE);
        end else begin
            grp_s    = 2'd0;
            tl_cnt_s = '0;
        end
        case (state_s)
            ST_OS:   d_sel_s = {1'b0, os_sel_s};
            ST_TL:   d_sel_s = SEL_TL;
            default: d_sel_s = SEL_IDLE;
        endcase
        os_ack_s   = (state_s == ST_OS) && (os_cnt_s == OS_LAST);
        tl_grant_s = (state_s == ST_TL);
        busy_s     = (state_s != ST_IDLE);
    end

    // State and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            os_cnt_r <= 4'd0;
            os_sel_r <= 3'd0;
            grp_r    <= 2'd0;
            tl_cnt_r <= '0;
        end else begin
            state_r  <= state_s;
            os_cnt_r <= os_cnt_s;
            os_sel_r <= os_sel_s;
            grp_r    <= grp_s;
            tl_cnt_r <= tl_cnt_s;
        end
    end

    // Registered transmit and receive outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_sel    <= SEL_IDLE;
            os_ack   <= 1'b0;
            tl_grant <= 1'b0;
            busy     <= 1'b0;
            enable_t <= 1'b0;
            enable_r <= 1'b0;
            data_os  <= 1'b0;
        end else begin
            d_sel    <= d_sel_s;
            os_ack   <= os_ack_s;
            tl_grant <= tl_grant_s;
            busy     <= busy_s;
            enable_t <= link_en;
            enable_r <= rx_en;
            data_os  <= rx_en & rx_tl;
        end
    end

endmodule

// File: tb/tb_lane_tx_scheduler.sv
// Self-checking bench for lane_tx_scheduler: a burst-plan model (queue of planned
// output cycles) is compared every cycle, plus directed literal expectations.
module tb_lane_tx_scheduler;

    localparam int OS_LEN = 4;
    localparam int TL_MAX = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       link_en, os_req, tl_req, rx_en, rx_tl;
    logic [2:0] os_sel;
    logic       os_ack, tl_grant, enable_t, enable_r, data_os, busy;
    logic [3:0] d_sel;

    lane_tx_scheduler #(.OS_LEN(OS_LEN), .TL_MAX(TL_MAX)) dut (
        .clk(clk), .rst(rst), .link_en(link_en), .os_req(os_req), .os_sel(os_sel),
        .os_ack(os_ack), .tl_req(tl_req), .tl_grant(tl_grant), .d_sel(d_sel),
        .enable_t(enable_t), .rx_en(rx_en), .rx_tl(rx_tl), .enable_r(enable_r),
        .data_os(data_os), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sel;
        logic       ack;
        logic       grant;
    } ent_t;

    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    ent_t plan[$];
    ent_t m_cur;
    logic m_busy, m_en_t, m_en_r, m_data_os;
    bit   m_last_tl;
    int   tl_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        plan.delete();
        m_cur.sel   = 4'hF;
        m_cur.ack   = 1'b0;
        m_cur.grant = 1'b0;
        m_busy = 1'b0; m_en_t = 1'b0; m_en_r = 1'b0; m_data_os = 1'b0;
        m_last_tl = 1'b0; tl_run = 0;
    endtask

    // Plan-level model: when the current plan runs out, decide the next burst.
    task automatic model_step();
        ent_t e;
        if (rst) begin
            model_reset();
            return;
        end
        m_en_t    = link_en;
        m_en_r    = rx_en;
        m_data_os = rx_en & rx_tl;
        if (!link_en) begin
            plan.delete();
            m_last_tl = 1'b0;
            tl_run = 0;
        end else if (plan.size() == 0) begin
            if (os_req && (!m_last_tl || tl_run >= TL_MAX || !tl_req)) begin
                for (int k = 0; k < OS_LEN; k++) begin
                    e.sel = {1'b0, os_sel};
                    e.ack = (k == OS_LEN - 1);
                    e.grant = 1'b0;
                    plan.push_back(e);
                end
                m_last_tl = 1'b0;
                tl_run = 0;
            end else if (tl_req) begin
                for (int k = 0; k < 4; k++) begin
                    e.sel = 4'h8; e.ack = 1'b0; e.grant = 1'b1;
                    plan.push_back(e);
                end
                tl_run += 4;
                m_last_tl = 1'b1;
            end else begin
                m_last_tl = 1'b0;
                tl_run = 0;
            end
        end
        if (plan.size() > 0) begin
            m_cur  = plan.pop_front();
            m_busy = 1'b1;
        end else begin
            m_cur.sel = 4'hF; m_cur.ack = 1'b0; m_cur.grant = 1'b0;
            m_busy = 1'b0;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("d_sel", d_sel, m_cur.sel);
            check("os_ack", os_ack, m_cur.ack);
            check("tl_grant", tl_grant, m_cur.grant);
            check("busy", busy, m_busy);
            check("enable_t", enable_t, m_en_t);
            check("enable_r", enable_r, m_en_r);
            check("data_os", data_os, m_data_os);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, first2, n_a, n_b, ack_i, n_ack, tl_n;
        logic [3:0] resume;
        rst = 1'b1; link_en = 1'b0; os_req = 1'b0; os_sel = 3'd0;
        tl_req = 1'b0; rx_en = 1'b0; rx_tl = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_d_sel", d_sel, 4'hF);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        chk_en = 1'b1;
        cyc();

        // OS only
        link_en = 1'b1; os_req = 1'b1; os_sel = 3'd5;
        first = 0; n_a = 0; ack_i = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (d_sel == 4'd5) begin
                n_a++;
                if (first == 0) first = i;
            end
            if (os_ack) begin
                ack_i = i;
                os_req = 1'b0;
            end
        end
        check("os_first_cycle", first, 1);
        check("os_len", n_a, 4);
        check("os_ack_cycle", ack_i, 4);
        check("os_then_idle", d_sel, 4'hF);

        // TL only: request for 6 cycles gives two full groups
        tl_req = 1'b1;
        tl_n = 0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 7) tl_req = 1'b0;
            cyc();
            if (tl_grant) tl_n++;
        end
        check("tl_grant_cycles", tl_n, 8);
        check("tl_then_idle", d_sel, 4'hF);

        // Fairness: OS waits for TL_MAX transport cycles
        tl_req = 1'b1; os_sel = 3'd3;
        first = 0; tl_n = 0; ack_i = 0; resume = 4'h0;
        for (int i = 1; i <= 26; i++) begin
            if (i == 3) os_req = 1'b1;
            cyc();
            if (first == 0 && tl_grant) tl_n++;
            if (first == 0 && d_sel == 4'd3) first = i;
            if (os_ack) begin
                ack_i = i;
                os_req = 1'b0;
            end
            if (i == 21) resume = d_sel;
        end
        check("fair_tl_run", tl_n, TL_MAX);
        check("fair_os_start", first, TL_MAX + 1);
        check("fair_os_ack", ack_i, TL_MAX + 4);
        check("fair_tl_resume", resume, 4'h8);
        tl_req = 1'b0;
        repeat (8) cyc();
        check("fair_idle", d_sel, 4'hF);

        // Back-to-back bursts with no gap
        os_req = 1'b1; os_sel = 3'd1;
        n_a = 0; n_b = 0; first2 = 0; n_ack = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (d_sel == 4'd1) n_a++;
            if (d_sel == 4'd2) begin
                n_b++;
                if (first2 == 0) first2 = i;
            end
            if (os_ack) begin
                n_ack++;
                if (n_ack == 1) os_sel = 3'd2;
                else os_req = 1'b0;
            end
        end
        check("b2b_first_len", n_a, 4);
        check("b2b_second_len", n_b, 4);
        check("b2b_second_start", first2, 5);

        // Abort mid-burst, then full restart
        os_req = 1'b1; os_sel = 3'd6; n_ack = 0;
        cyc(); if (os_ack) n_ack++;
        cyc(); if (os_ack) n_ack++;
        link_en = 1'b0;
        cyc(); if (os_ack) n_ack++;
        check("abort_d_sel", d_sel, 4'hF);
        check("abort_enable_t", enable_t, 1'b0);
        check("abort_no_ack", n_ack, 0);
        cyc();
        link_en = 1'b1;
        first = 0; n_a = 0; ack_i = 0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (d_sel == 4'd6) begin
                n_a++;
                if (first == 0) first = i;
            end
            if (os_ack) begin
                ack_i = i;
                os_req = 1'b0;
            end
        end
        check("restart_first", first, 1);
        check("restart_len", n_a, 4);
        check("restart_ack", ack_i, 4);

        // Receive side
        rx_en = 1'b1; rx_tl = 1'b1;
        cyc(); check("rx_data_os_1", data_os, 1'b1); check("rx_enable_r", enable_r, 1'b1);
        rx_tl = 1'b0;
        cyc(); check("rx_data_os_0", data_os, 1'b0);
        rx_tl = 1'b1;
        cyc(); check("rx_data_os_1b", data_os, 1'b1);
        rx_en = 1'b0;
        cyc(); check("rx_off_enable_r", enable_r, 1'b0); check("rx_off_data_os", data_os, 1'b0);

        // Asynchronous reset mid-TL
        rx_en = 1'b1; tl_req = 1'b1;
        repeat (3) cyc();
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_d_sel", d_sel, 4'hF);
        check("arst_enable_t", enable_t, 1'b0);
        check("arst_tl_grant", tl_grant, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_enable_r", enable_r, 1'b0);
        check("arst_data_os", data_os, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();
        check("arst_resume_tl", d_sel, 4'h8);
        tl_req = 1'b0;
        repeat (6) cyc();
        check("final_idle", d_sel, 4'hF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lane_tx_scheduler.md
# lane_tx_scheduler

Controller that sequences the two-lane distributer in the USB4 logical layer. It arbitrates the transmit slot between the ordered-set generator and the transport-layer data bus. It drives `d_sel` and `enable_t` so that transport bursts always span whole 4-cycle lane groups, and it registers the receive-side `enable_r` and `data_os` controls.

## Interface
Parameters:
- `OS_LEN`, 4: cycles one ordered-set burst occupies; legal range 1–15.
- `TL_MAX`, 16: maximum transport cycles held while `os_req` is pending; must be a multiple of 4, at least 4.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `link_en` in 1: transmit path enable; low aborts all activity.
- `os_req` in 1: ordered-set request; level, held until `os_ack`.
- `os_sel` in 3: ordered-set type, mapped to `d_sel` 0–7; sampled at burst start.
- `os_ack` out 1: one-cycle pulse on the last cycle of an ordered-set burst.
- `tl_req` in 1: transport-layer data available; level.
- `tl_grant` out 1: high in every cycle a transport byte is consumed on lane 0.
- `d_sel` out 4: distributer select; 0–7 ordered set, 8 transport, 4'hF idle.
- `enable_t` out 1: distributer transmit enable.
- `rx_en` in 1: receive path enable from the link-training block.
- `rx_tl` in 1: receive stream currently carries transport data.
- `enable_r` out 1: distributer receive enable.
- `data_os` out 1: distributer receive mode; 1 = transport, 0 = ordered sets.
- `busy` out 1: FSM not in IDLE.

## Operation
- FSM states: IDLE, OS, TL. All outputs are registered.
- A group counter `grp[1:0]` runs only in TL and wraps 3→0. It is cleared on entry to TL.
- IDLE:
  - `d_sel`=4'hF, `tl_grant`=0.
  - If `link_en` and `os_req`: go to OS. Ordered sets have priority over transport.
  - Else if `link_en` and `tl_req`: go to TL.
- OS:
  - `d_sel`={1'b0, latched `os_sel`} for exactly `OS_LEN` cycles. `os_ack` pulses in the final cycle.
  - Next state: OS again if `os_req` is still high after the ack cycle (back-to-back bursts with no gap), otherwise TL if `tl_req`, otherwise IDLE.
- TL:
  - `d_sel`=8 and `tl_grant`=1 every cycle.
  - A TL run counter `tl_cnt` counts cycles in the TL state.
  - Exit is evaluated only when `grp`==3, so every TL residency is a multiple of 4 cycles and distributer lane alignment is preserved.
  - At `grp`==3: go to OS if `os_req` and (`tl_cnt`+1 ≥ `TL_MAX` or `tl_req`=0). Otherwise go to IDLE if `tl_req`=0. Otherwise stay in TL.
  - If `tl_req` drops mid-group, `tl_grant` stays high until the group completes. The transport bus must pad the remaining bytes.
- `enable_t` is registered from `link_en`.
- When `link_en` is low:
  - FSM forced to IDLE next cycle; `grp` and `tl_cnt` cleared.
  - No `os_ack` is issued for an aborted burst; the requester keeps `os_req` high and the burst restarts from cycle 0.
- Receive side:
  - `enable_r` is registered from `rx_en`.
  - `data_os` is registered from `rx_en & rx_tl`, so it is forced to 0 whenever `rx_en` is low.
- Reset values: `d_sel`=4'hF; all other outputs 0; FSM in IDLE; all counters 0.

## Timing
- Request to first select cycle: `os_req` or `tl_req` sampled high in IDLE gives the new `d_sel` on the next edge (1-cycle latency).
- Ordered-set burst: exactly `OS_LEN` cycles. `os_ack` coincides with the last `d_sel` cycle of the burst.
- OS→TL and TL→OS transitions have zero idle cycles.
- Worst-case ordered-set wait from TL: `TL_MAX`+1 cycles.
- `link_en` falling at edge N:
  - `enable_t`=0 and `d_sel`=4'hF from edge N+1.
  - If `link_en` rises again, the FSM re-arbitrates from IDLE with a fresh group.
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronous). Operation resumes from IDLE on the first edge after release.
- Simultaneous `os_req` and `tl_req` in IDLE: OS wins.

## Test plan
- Reset: assert `rst` mid-TL → `d_sel`=4'hF and `enable_t`=`tl_grant`=`busy`=`enable_r`=`data_os`=0 immediately; FSM resumes from IDLE after release.
- OS only: `link_en`=1, `os_req`=1, `os_sel`=5, default `OS_LEN` → `d_sel`=5 for 4 cycles, `os_ack` on the 4th cycle; drop `os_req` → `d_sel`=4'hF.
- TL only: `tl_req` high for 6 cycles → `d_sel`=8 and `tl_grant`=1 for exactly 8 cycles, then `d_sel`=4'hF.
- Fairness: `tl_req` held high, `os_req` raised at TL cycle 2 → TL continues to cycle 16 (`TL_MAX`); `d_sel`=`os_sel` from cycle 17 for 4 cycles; TL resumes with `grp`=0.
- Abort: `link_en` dropped at OS cycle 2 → no `os_ack`; `d_sel`=4'hF next cycle; after re-enable, a full 4-cycle burst is produced.
- Receive: `rx_en`=1, `rx_tl` toggled → `data_os` follows with 1-cycle delay; `rx_en`=0 → `enable_r`=`data_os`=0 next cycle.
